// File: rtl/mcpu_ram_bist_if.sv
// RAM controller port bundle driven by the BIST: write port, data-read port, instruction-read port.
interface mcpu_ram_bist_if #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  we;
  logic [WORD_SIZE-1:0]  datawr;
  logic                  re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_SIZE-1:0]  datard;
  logic [ADDR_WIDTH-1:0] instraddr;
  logic [WORD_SIZE-1:0]  instrrd;

  modport master (
    output we, datawr, re, addr, instraddr,
    input  datard, instrrd
  );

  modport slave (
    input  we, datawr, re, addr, instraddr,
    output datard, instrrd
  );
endinterface

// File: rtl/mcpu_ram_bist.sv
// Built-in self-test initiator for the MicroCPU RAM: fills every word, then checks it back through
// the data and instruction read ports simultaneously, walking them in opposite directions.
module mcpu_ram_bist #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter int unsigned          RAM_SIZE   = 1 << ADDR_WIDTH,
  parameter logic [WORD_SIZE-1:0] PATTERN    = 16'h0FAC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  addr_mode,
  mcpu_ram_bist_if.master       ram,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_port
);

  localparam int unsigned           CntW     = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWSet,
    StWStb,
    StRRun,
    StRLast,
    StDone
  } state_e;

  state_e state_q;
  logic   mode_q;
  logic   seen_q;

  logic            d_err;
  logic            i_err;
  logic [CntW-1:0] err_next;

  function automatic logic [WORD_SIZE-1:0] expected(input logic                  mode,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [WORD_SIZE-1:0] a_ext;
    a_ext = WORD_SIZE'(a);
    return mode ? (PATTERN ^ a_ext) : PATTERN;
  endfunction

  assign d_err    = ram.datard != expected(mode_q, ram.addr);
  assign i_err    = ram.instrrd != expected(mode_q, ram.instraddr);
  assign err_next = err_count + CntW'(d_err) + CntW'(i_err);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      mode_q        <= 1'b0;
      seen_q        <= 1'b0;
      ram.we        <= 1'b0;
      ram.re        <= 1'b0;
      ram.addr      <= '0;
      ram.instraddr <= '0;
      ram.datawr    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      fail_addr     <= '0;
      fail_port     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mode_q        <= addr_mode;
            seen_q        <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_addr     <= '0;
            fail_port     <= 1'b0;
            busy          <= 1'b1;
            ram.addr      <= '0;
            ram.instraddr <= '0;
            ram.datawr    <= PATTERN;
            state_q       <= StWSet;
          end
        end
        StWSet: begin
          ram.we  <= 1'b1;
          state_q <= StWStb;
        end
        StWStb: begin
          // Address and data only move on the edge that drops we.
          ram.we <= 1'b0;
          if (ram.addr == LastAddr) begin
            ram.addr      <= '0;
            ram.instraddr <= LastAddr;
            ram.re        <= 1'b1;
            state_q       <= StRRun;
          end else begin
            ram.addr   <= ram.addr + 1'b1;
            ram.datawr <= expected(mode_q, ram.addr + 1'b1);
            state_q    <= StWSet;
          end
        end
        StRRun: begin
          err_count <= err_next;
          if (!seen_q && (d_err || i_err)) begin
            seen_q    <= 1'b1;
            fail_port <= !d_err;
            fail_addr <= d_err ? ram.addr : ram.instraddr;
          end
          // Last compare: stop without wrapping; re covers exactly one cycle per word.
          if (ram.addr == LastAddr) begin
            ram.re  <= 1'b0;
            state_q <= StRLast;
          end else begin
            ram.addr      <= ram.addr + 1'b1;
            ram.instraddr <= ram.instraddr - 1'b1;
          end
        end
        StRLast: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_count == '0);
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_ram_bist.sv
// Self-checking bench for mcpu_ram_bist: a faultable RAM model plus a whole-test outcome model.
module tb_mcpu_ram_bist;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       addr_mode;
  logic       busy;
  logic       done;
  logic       pass;
  logic [9:0] err_count;
  logic [7:0] fail_addr;
  logic       fail_port;

  int checks = 0;
  int errors = 0;

  // 0 none, 1 data-port bit flips, 2 instruction-port bit flips, 3 address bit 7 ignored
  int          fault_kind = 0;
  logic [7:0]  fault_addr = '0;
  logic [15:0] fault_mask = '0;

  logic [15:0] mem [256];
  logic [7:0]  w_idx;
  logic [7:0]  d_idx;
  logic [7:0]  i_idx;

  mcpu_ram_bist_if #(.WORD_SIZE(16), .ADDR_WIDTH(8)) bus ();

  mcpu_ram_bist #(
    .WORD_SIZE (16),
    .ADDR_WIDTH(8),
    .RAM_SIZE  (256),
    .PATTERN   (16'h0FAC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr_mode(addr_mode),
    .ram      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .fail_port(fail_port)
  );

  always #5 clk = ~clk;

  assign w_idx = (fault_kind == 3) ? {1'b0, bus.addr[6:0]} : bus.addr;
  assign d_idx = w_idx;
  assign i_idx = (fault_kind == 3) ? {1'b0, bus.instraddr[6:0]} : bus.instraddr;
  assign bus.datard  = mem[d_idx] ^
                       ((fault_kind == 1 && bus.addr == fault_addr) ? fault_mask : 16'h0);
  assign bus.instrrd = mem[i_idx] ^
                       ((fault_kind == 2 && bus.instraddr == fault_addr) ? fault_mask : 16'h0);

  always @(posedge clk) begin
    if (bus.we) mem[w_idx] <= bus.datawr;
  end

  function automatic logic [15:0] expv(input logic mode, input logic [7:0] a);
    return mode ? (16'h0FAC ^ {8'h00, a}) : 16'h0FAC;
  endfunction

  function automatic logic [7:0] phys(input logic [7:0] a);
    return (fault_kind == 3) ? {1'b0, a[6:0]} : a;
  endfunction

  // Outcome of a whole test: fill RAM in address order, then read word i on the data port
  // alongside word 255-i on the instruction port.
  task automatic ref_model(input logic mode, output int e_err, output logic [7:0] e_fa,
                           output logic e_fp);
    logic [15:0] m [256];
    logic [15:0] dv, iv;
    logic [7:0]  da, ia;
    bit          de, ie, found;
    for (int a = 0; a < 256; a++) m[phys(8'(a))] = expv(mode, 8'(a));
    e_err = 0; e_fa = '0; e_fp = 1'b0; found = 0;
    for (int i = 0; i < 256; i++) begin
      da = 8'(i);
      ia = 8'(255 - i);
      dv = m[phys(da)] ^ ((fault_kind == 1 && da == fault_addr) ? fault_mask : 16'h0);
      iv = m[phys(ia)] ^ ((fault_kind == 2 && ia == fault_addr) ? fault_mask : 16'h0);
      de = dv != expv(mode, da);
      ie = iv != expv(mode, ia);
      e_err += int'(de) + int'(ie);
      if (!found && (de || ie)) begin
        found = 1;
        e_fp  = !de;
        e_fa  = de ? da : ia;
      end
    end
  endtask

  // Starts a test and follows it to done; optionally re-pulses start at read address 0x20 or
  // asserts reset during the write strobe at address 0x40 (returning with reset held).
  task automatic run_bist(input logic mode, input bit restart_en, input bit abort_en,
                          output int edges, output int we_n, output int re_n,
                          output int wr_bad, output bit both_hi, output bit first_done,
                          output bit ok, output bit aborted);
    bit fired;
    fired = 0; edges = 0; we_n = 0; re_n = 0; wr_bad = 0;
    both_hi = 0; first_done = 1; ok = 0; aborted = 0;
    @(negedge clk);
    addr_mode = mode;
    start     = 1'b1;
    @(posedge clk);
    while (!ok && !aborted && edges < 2000) begin
      @(negedge clk);
      start = 1'b0;
      if (edges == 0) first_done = done;
      if (bus.we) begin
        we_n++;
        if (bus.datawr !== expv(mode, bus.addr)) wr_bad++;
      end
      if (bus.re) re_n++;
      if (busy && done) both_hi = 1;
      if (done) ok = 1;
      if (restart_en && !fired && bus.re && bus.addr == 8'h20) begin
        start = 1'b1;
        fired = 1;
      end
      if (abort_en && bus.we && bus.addr == 8'h40) begin
        reset   = 1'b1;
        aborted = 1;
      end
      if (!ok && !aborted) begin
        @(posedge clk);
        edges++;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; addr_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.we, bus.re, busy, done, pass, fail_port} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.we, bus.re, busy, done, pass, fail_port});
    end
    checks++;
    if ({err_count, fail_addr} !== 18'h0) begin
      errors++;
      $display("FAIL reset_status: got err=%0d fa=%h expected 0 0", err_count, fail_addr);
    end
    checks++;
    if ({bus.addr, bus.instraddr, bus.datawr} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h %h %h expected zeros", bus.addr, bus.instraddr,
               bus.datawr);
    end
    reset = 1'b0;
  endtask

  task automatic test_pattern_mode0;
    int edges, we_n, re_n, wr_bad, bad_words;
    bit both_hi, fd, ok, ab;
    fault_kind = 0;
    run_bist(1'b0, 0, 0, edges, we_n, re_n, wr_bad, both_hi, fd, ok, ab);
    checks++;
    if (!ok || edges != 769) begin
      errors++;
      $display("FAIL done_timing: got ok=%0d edge=%0d expected 1 769", ok, edges);
    end
    checks++;
    if (we_n != 256 || wr_bad != 0) begin
      errors++;
      $display("FAIL we_pulses: got %0d pulses %0d bad data expected 256 0", we_n, wr_bad);
    end
    checks++;
    if (re_n != 256) begin
      errors++;
      $display("FAIL re_cycles: got %0d expected 256", re_n);
    end
    checks++;
    if (both_hi) begin
      errors++;
      $display("FAIL busy_done_overlap: got 1 expected 0");
    end
    bad_words = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== 16'h0FAC) bad_words++;
    checks++;
    if (bad_words != 0) begin
      errors++;
      $display("FAIL fill_mode0: got %0d wrong words expected 0", bad_words);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 10'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL result_mode0: got pass=%b err=%0d busy=%b expected 1 0 0", pass,
               err_count, busy);
    end
  endtask

  task automatic check_fault_run(input string name, input logic mode);
    int edges, we_n, re_n, wr_bad, e_err;
    bit both_hi, fd, ok, ab;
    logic [7:0] e_fa;
    logic e_fp;
    ref_model(mode, e_err, e_fa, e_fp);
    run_bist(mode, 0, 0, edges, we_n, re_n, wr_bad, both_hi, fd, ok, ab);
    checks++;
    if (!ok || edges != 769 || err_count !== 10'(e_err) || fail_addr !== e_fa ||
        fail_port !== e_fp || pass !== (e_err == 0)) begin
      errors++;
      $display("FAIL %s: got ok=%0d edge=%0d err=%0d fa=%h fp=%b pass=%b expected 1 769 %0d %h %b %b",
               name, ok, edges, err_count, fail_addr, fail_port, pass, e_err, e_fa, e_fp,
               e_err == 0);
    end
  endtask

  task automatic test_data_fault;
    fault_kind = 1; fault_addr = 8'h05; fault_mask = 16'h0008;
    check_fault_run("data_fault_model", 1'b1);
    checks++;
    if (err_count !== 10'd1 || fail_addr !== 8'h05 || fail_port !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL data_fault: got err=%0d fa=%h fp=%b pass=%b expected 1 05 0 0",
               err_count, fail_addr, fail_port, pass);
    end
  endtask

  task automatic test_instr_fault;
    fault_kind = 2; fault_addr = 8'hFA; fault_mask = 16'($urandom_range(1, 16'hFFFF));
    check_fault_run("instr_fault_model", 1'($urandom_range(0, 1)));
    checks++;
    if (err_count !== 10'd1 || fail_addr !== 8'hFA || fail_port !== 1'b1) begin
      errors++;
      $display("FAIL instr_fault: got err=%0d fa=%h fp=%b expected 1 fa 1", err_count,
               fail_addr, fail_port);
    end
  endtask

  task automatic test_alias;
    fault_kind = 3;
    check_fault_run("alias_mode1_model", 1'b1);
    checks++;
    if (err_count !== 10'd256 || fail_addr !== 8'h00 || fail_port !== 1'b0) begin
      errors++;
      $display("FAIL alias_mode1: got err=%0d fa=%h fp=%b expected 256 00 0", err_count,
               fail_addr, fail_port);
    end
    check_fault_run("alias_mode0_model", 1'b0);
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL alias_mode0: got pass=%b expected 1", pass);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      fault_kind = int'($urandom_range(0, 3));
      fault_addr = 8'($urandom_range(0, 255));
      fault_mask = 16'($urandom_range(1, 16'hFFFF));
      check_fault_run($sformatf("random_%0d_kind%0d", r, fault_kind),
                      1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    int edges, we_n, re_n, wr_bad;
    bit both_hi, fd, ok, ab;
    fault_kind = 0;
    run_bist(1'b1, 0, 1, edges, we_n, re_n, wr_bad, both_hi, fd, ok, ab);
    checks++;
    if (!ab) begin
      errors++;
      $display("FAIL reset_mid_reach: got reached=%0d expected 1", ab);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.we, bus.re, busy, done, pass, fail_port} !== 6'b0 || err_count !== 10'd0 ||
        fail_addr !== 8'h00 || {bus.addr, bus.instraddr, bus.datawr} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got we=%b re=%b busy=%b done=%b addr=%h dw=%h expected zeros",
               bus.we, bus.re, busy, done, bus.addr, bus.datawr);
    end
    reset = 1'b0;
    run_bist(1'b1, 0, 0, edges, we_n, re_n, wr_bad, both_hi, fd, ok, ab);
    checks++;
    if (!ok || edges != 769 || pass !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rerun: got ok=%0d edge=%0d pass=%b expected 1 769 1", ok, edges,
               pass);
    end
  endtask

  task automatic test_start_ignored;
    int edges, we_n, re_n, wr_bad;
    bit both_hi, fd, ok, ab;
    fault_kind = 0;
    run_bist(1'b0, 1, 0, edges, we_n, re_n, wr_bad, both_hi, fd, ok, ab);
    checks++;
    if (!ok || edges != 769 || re_n != 256 || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: got ok=%0d edge=%0d re=%0d pass=%b expected 1 769 256 1",
               ok, edges, re_n, pass);
    end
  endtask

  task automatic test_restart_in_done;
    int edges, we_n, re_n, wr_bad;
    bit both_hi, fd, ok, ab;
    fault_kind = 1; fault_addr = 8'h80; fault_mask = 16'h8000;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_held: got %b expected 1", done);
    end
    run_bist(1'b0, 0, 0, edges, we_n, re_n, wr_bad, both_hi, fd, ok, ab);
    checks++;
    if (fd !== 1'b0) begin
      errors++;
      $display("FAIL restart_done_clear: got %b expected 0", fd);
    end
    checks++;
    if (!ok || edges != 769 || err_count !== 10'd1 || fail_addr !== 8'h80) begin
      errors++;
      $display("FAIL restart_rerun: got ok=%0d edge=%0d err=%0d fa=%h expected 1 769 1 80", ok,
               edges, err_count, fail_addr);
    end
  endtask

  initial begin
    test_reset();
    test_pattern_mode0();
    test_data_fault();
    test_instr_fault();
    test_alias();
    test_random();
    test_reset_mid();
    test_start_ignored();
    test_restart_in_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
